// File: rtl/aes_wb_ctrl.sv
// Wishbone slave register block and launch/wait sequencer for the AES datapath core.
// Holds key, input block and result words; reports completion, errors and watchdog aborts.
module aes_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         core_start_o,
  output logic         core_mode_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_din_o,
  input  logic         core_done_i,
  input  logic [127:0] core_dout_i,
  output logic         irq_o
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_mode;
  logic              r_irq_en;
  logic              r_done;
  logic              r_err;
  logic              r_tmo;
  logic [WDOG_W-1:0] r_wdog;
  logic [31:0]       r_key  [4];
  logic [31:0]       r_din  [4];
  logic [31:0]       r_dout [4];

  logic        w_req, w_hit, w_wr, w_rd, w_busy;
  logic [5:0]  w_off;
  logic        w_wr_ctrl, w_wr_stat, w_wr_key, w_wr_din, w_ctrl_b0;
  logic        w_start, w_mode_chg, w_launch, w_busy_err;
  logic        w_done, w_tmo;
  logic [2:0]  w_w1c;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Ack low in the request term guarantees a held strobe is acked every other cycle.
  assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_off      = wbs_adr_i[7:2];
  assign w_wr       = w_req & wbs_we_i & w_hit;
  assign w_rd       = w_req & ~wbs_we_i & w_hit;
  assign w_busy     = (r_state != S_IDLE);
  assign w_unused   = ^wbs_adr_i[1:0];

  assign w_wr_ctrl  = w_wr & (w_off == 6'd0);
  assign w_wr_stat  = w_wr & (w_off == 6'd1);
  assign w_wr_key   = w_wr & (w_off[5:2] == 4'd1);
  assign w_wr_din   = w_wr & (w_off[5:2] == 4'd2);
  assign w_ctrl_b0  = w_wr_ctrl & wbs_sel_i[0];
  assign w_start    = w_ctrl_b0 & wbs_dat_i[0];
  assign w_mode_chg = w_ctrl_b0 & (wbs_dat_i[1] != r_mode);
  assign w_launch   = w_start & ~w_busy;
  assign w_busy_err = w_busy & (w_start | w_mode_chg | w_wr_key | w_wr_din);
  assign w_w1c      = (w_wr_stat & wbs_sel_i[0]) ? wbs_dat_i[3:1] : 3'b000;

  // Done takes priority if it lands on the last watchdog cycle.
  assign w_done     = (r_state == S_WAIT) & core_done_i;
  assign w_tmo      = (r_state == S_WAIT) & ~core_done_i & (r_wdog == WDOG_LAST);

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    core_start_o = 1'b0;
    case (r_state)
      S_IDLE:   if (w_launch) w_state_next = S_LAUNCH;
      S_LAUNCH: begin
        core_start_o = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT:   if (w_done || w_tmo) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_off[5:2])
      4'd0: begin
        if (w_off[1:0] == 2'd0) w_rdata = {29'd0, r_irq_en, r_mode, 1'b0};
        else if (w_off[1:0] == 2'd1) w_rdata = {28'd0, r_tmo, r_err, r_done, w_busy};
      end
      4'd2:    w_rdata = r_din[w_off[1:0]];
      4'd3:    w_rdata = r_dout[w_off[1:0]];
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_mode   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_ctrl_b0) begin
        r_irq_en <= wbs_dat_i[2];
        if (!w_busy) r_mode <= wbs_dat_i[1];
      end
      // Sticky flags: a set on the same edge as a W1C wins.
      r_done <= w_done | (r_done & ~w_w1c[0]);
      r_err  <= w_tmo | w_busy_err | (r_err & ~w_w1c[1]);
      r_tmo  <= w_tmo | (r_tmo & ~w_w1c[2]);
      if (r_state == S_LAUNCH) r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        r_key[gi]  <= '0;
        r_din[gi]  <= '0;
        r_dout[gi] <= '0;
      end else begin
        if (w_wr_key && !w_busy && (w_off[1:0] == 2'(gi)))
          r_key[gi] <= f_merge(r_key[gi], wbs_dat_i, wbs_sel_i);
        if (w_wr_din && !w_busy && (w_off[1:0] == 2'(gi)))
          r_din[gi] <= f_merge(r_din[gi], wbs_dat_i, wbs_sel_i);
        if (w_done)
          r_dout[gi] <= core_dout_i[127-32*gi -: 32];
      end
    end

    // Word 0 sits in the most significant lane.
    assign core_key_o[127-32*gi -: 32] = r_key[gi];
    assign core_din_o[127-32*gi -: 32] = r_din[gi];
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign core_mode_o = r_mode;
  assign irq_o       = r_irq_en & (r_done | r_err);

endmodule

// File: tb/tb_aes_wb_ctrl.sv
// Self-checking bench for aes_wb_ctrl: directed flows plus randomized bus traffic
// compared against a transaction-level register model.
module tb_aes_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          T    = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_w;
  logic         ack;
  logic [31:0]  dat_r;
  logic         core_start, core_mode;
  logic [127:0] core_key, core_din;
  logic         core_done;
  logic [127:0] core_dout;
  logic         irq;

  int n_chk  = 0;
  int n_pass = 0;

  int           n_start = 0;
  logic [127:0] cap_key = '0;
  logic [127:0] cap_din = '0;
  logic         cap_mode = 1'b0;

  logic [31:0] m_key [4];
  logic [31:0] m_din [4];
  logic [31:0] m_dout[4];
  logic        m_mode, m_irq_en, m_done, m_err, m_tmo, m_busy;

  always #5 clk = ~clk;

  aes_wb_ctrl #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_w),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_r),
    .core_start_o(core_start),
    .core_mode_o (core_mode),
    .core_key_o  (core_key),
    .core_din_o  (core_din),
    .core_done_i (core_done),
    .core_dout_i (core_dout),
    .irq_o       (irq)
  );

  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      n_start  <= n_start + 1;
      cap_key  <= core_key;
      cap_din  <= core_din;
      cap_mode <= core_mode;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_din[i] = '0; m_dout[i] = '0;
    end
    m_mode = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_tmo = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int off;
    if (a[31:8] != BASE[31:8]) return;
    off = int'(a[7:2]);
    if (off == 0 && s[0]) begin
      m_irq_en = d[2];
      if (m_busy) begin
        if (d[0] || d[1] != m_mode) m_err = 1;
      end else begin
        m_mode = d[1];
        if (d[0]) m_busy = 1;
      end
    end else if (off == 1 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err  = 0;
      if (d[3]) m_tmo  = 0;
    end else if (off >= 4 && off <= 11) begin
      if (m_busy) m_err = 1;
      else if (off < 8) m_key[off-4] = m_merge(m_key[off-4], d, s);
      else m_din[off-8] = m_merge(m_din[off-8], d, s);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off;
    if (a[31:8] != BASE[31:8]) return 32'd0;
    off = int'(a[7:2]);
    if (off == 0) return {29'd0, m_irq_en, m_mode, 1'b0};
    if (off == 1) return {28'd0, m_tmo, m_err, m_done, m_busy};
    if (off >= 8 && off <= 11) return m_din[off-8];
    if (off >= 12 && off <= 15) return m_dout[off-12];
    return 32'd0;
  endfunction

  function automatic logic m_irq();
    return m_irq_en & (m_done | m_err);
  endfunction

  task automatic m_complete(input logic [127:0] res);
    m_busy = 0;
    m_done = 1;
    for (int i = 0; i < 4; i++) m_dout[i] = res[127-32*i -: 32];
  endtask

  // ---------------- bus and core drivers ----------------
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int n;
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 4);
    check("ack_seen", ack, 1'b1);
    r = dat_r;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check("ack_single", ack, 1'b0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, s, r);
    m_write(a, d, s);
  endtask

  task automatic rd_val(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic rd_chk(input logic [31:0] a, input string tag);
    logic [31:0] r;
    rd_val(a, r);
    check(tag, r, m_read(a));
  endtask

  task automatic pulse_done(input logic [127:0] res);
    core_dout = res;
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    if (m_busy) m_complete(res);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE + 32'h100 * $urandom_range(1, 3) + 4 * $urandom_range(0, 15);
    if (k == 1) return BASE + 4 * $urandom_range(16, 63);
    return BASE + 4 * $urandom_range(0, 15);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench stopped");
  end

  initial begin
    logic [31:0]  r;
    logic [127:0] rv;
    int           base, k, busy_iters;

    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
    core_done = 0; core_dout = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_start", core_start, 1'b0);
    check("rst_key", core_key, 128'd0);
    check("rst_irq", irq, 1'b0);
    rst_n = 1;
    @(negedge clk);
    rd_chk(BASE + 32'h04, "rst_status");
    rd_chk(BASE + 32'h30, "rst_dout0");
    rd_val(BASE + 32'h10, r);
    check("rst_key0_rd", r, 32'd0);

    // Encrypt flow with the FIPS-197 vector
    wb_write(BASE + 32'h10, 32'h2b7e1516, 4'hF);
    wb_write(BASE + 32'h14, 32'h28aed2a6, 4'hF);
    wb_write(BASE + 32'h18, 32'habf71588, 4'hF);
    wb_write(BASE + 32'h1C, 32'h09cf4f3c, 4'hF);
    wb_write(BASE + 32'h20, 32'h3243f6a8, 4'hF);
    wb_write(BASE + 32'h24, 32'h885a308d, 4'hF);
    wb_write(BASE + 32'h28, 32'h313198a2, 4'hF);
    wb_write(BASE + 32'h2C, 32'he0370734, 4'hF);
    base = n_start;
    wb_write(BASE, 32'h5, 4'hF);
    repeat (8) @(negedge clk);
    pulse_done(128'h3925841d_02dc09fb_dc118597_196a0b32);
    check("enc_start_pulses", n_start - base, 1);
    check("enc_key", cap_key, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    check("enc_din", cap_din, 128'h3243f6a8_885a308d_313198a2_e0370734);
    check("enc_mode", cap_mode, 1'b0);
    rd_val(BASE + 32'h04, r);
    check("enc_status", r, 32'h2);
    rd_chk(BASE + 32'h30, "enc_dout0");
    rd_chk(BASE + 32'h34, "enc_dout1");
    rd_chk(BASE + 32'h38, "enc_dout2");
    rd_val(BASE + 32'h3C, r);
    check("enc_dout3", r, 32'h196a0b32);
    check("enc_irq", irq, 1'b1);
    wb_write(BASE + 32'h04, 32'h2, 4'hF);
    check("enc_irq_clr", irq, 1'b0);

    // Busy protection
    wb_write(BASE, 32'h1, 4'hF);
    wb_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    rd_val(BASE + 32'h04, r);
    check("busy_status", r, 32'h5);
    rd_val(BASE + 32'h20, r);
    check("busy_din0", r, 32'h3243f6a8);
    rv = {$urandom(), $urandom(), $urandom(), $urandom()};
    pulse_done(rv);
    rd_val(BASE + 32'h04, r);
    check("busy_status_done", r, 32'h6);
    rd_chk(BASE + 32'h34, "busy_dout1");
    wb_write(BASE + 32'h04, 32'h6, 4'hF);

    // Byte lanes
    wb_write(BASE + 32'h24, 32'h0, 4'hF);
    wb_write(BASE + 32'h24, 32'hAABBCCDD, 4'b0101);
    rd_val(BASE + 32'h24, r);
    check("lanes_din1", r, 32'h00BB00DD);

    // Held strobe: one ack every other cycle
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h04; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("held_ack", ack, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    cyc = 0; stb = 0;
    @(negedge clk);

    // Foreign page access
    wb_write(BASE + 32'h120, 32'h1234_5678, 4'hF);
    rd_val(BASE + 32'h120, r);
    check("page_rd", r, 32'd0);
    rd_chk(BASE + 32'h20, "page_din0");

    // W1C of DONE on the same edge as completion
    wb_write(BASE, 32'h1, 4'hF);
    @(negedge clk);
    rv = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_dout = rv;
    core_done = 1;
    fork
      wb_xfer(1'b1, BASE + 32'h04, 32'h2, 4'hF, r);
      begin
        @(negedge clk);
        core_done = 0;
      end
    join
    m_complete(rv);
    rd_val(BASE + 32'h04, r);
    check("w1c_race_status", r, 32'h2);
    rd_chk(BASE + 32'h3C, "w1c_race_dout3");
    wb_write(BASE + 32'h04, 32'hE, 4'hF);

    // START on the same edge as completion
    wb_write(BASE, 32'h1, 4'hF);
    @(negedge clk);
    base = n_start;
    rv = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_dout = rv;
    core_done = 1;
    fork
      wb_xfer(1'b1, BASE, 32'h1, 4'hF, r);
      begin
        @(negedge clk);
        core_done = 0;
      end
    join
    m_complete(rv);
    m_err = 1;
    repeat (3) @(negedge clk);
    check("race_start_none", n_start - base, 0);
    rd_val(BASE + 32'h04, r);
    check("race_start_status", r, 32'h6);
    wb_write(BASE + 32'h04, 32'hE, 4'hF);

    // Watchdog timeout
    wb_write(BASE, 32'h5, 4'hF);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (irq !== 1'b1 && k < 40);
    check("tmo_cycles", k, T);
    m_busy = 0; m_tmo = 1; m_err = 1;
    rd_val(BASE + 32'h04, r);
    check("tmo_status", r, 32'hC);
    rd_chk(BASE + 32'h30, "tmo_dout0");
    repeat (2) @(negedge clk);
    pulse_done(~rv);
    rd_val(BASE + 32'h04, r);
    check("tmo_late_status", r, 32'hC);
    rd_chk(BASE + 32'h30, "tmo_late_dout0");
    rd_chk(BASE + 32'h3C, "tmo_late_dout3");
    wb_write(BASE + 32'h04, 32'hE, 4'hF);

    // Reset during WAIT
    wb_write(BASE, 32'h7, 4'hF);
    @(negedge clk);
    check("rw_mode_before", core_mode, 1'b1);
    rst_n = 0;
    #1;
    check("rw_start", core_start, 1'b0);
    check("rw_mode", core_mode, 1'b0);
    check("rw_key", core_key, 128'd0);
    check("rw_din", core_din, 128'd0);
    check("rw_irq", irq, 1'b0);
    check("rw_ack", ack, 1'b0);
    check("rw_dat", dat_r, 32'd0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    @(negedge clk);
    pulse_done({$urandom(), $urandom(), $urandom(), $urandom()});
    rd_chk(BASE + 32'h04, "rw_status");
    rd_chk(BASE + 32'h30, "rw_dout0");
    check("rw_irq_after", irq, 1'b0);

    // Randomized traffic against the model
    busy_iters = 0;
    for (int it = 0; it < 120; it++) begin
      int          op;
      logic [31:0] a, d;
      logic [3:0]  s;
      op = $urandom_range(0, 7);
      a  = rand_addr();
      d  = $urandom();
      s  = 4'($urandom_range(0, 15));
      if (op < 3) begin
        wb_write(a, d, s);
      end else if (op < 6) begin
        rd_chk(a, "rand_rd");
      end else if (op == 6) begin
        if (m_busy) pulse_done({$urandom(), $urandom(), $urandom(), $urandom()});
        else wb_write(BASE, {29'd0, d[2:1], 1'b1}, 4'h1);
      end else begin
        wb_write(BASE + 32'h04, {28'd0, d[3:1], 1'b0}, 4'h1);
      end
      if (m_busy) begin
        busy_iters++;
        if (busy_iters >= 3) pulse_done({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      if (!m_busy) busy_iters = 0;
      check("rand_irq", irq, m_irq());
      check("rand_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
      check("rand_din", core_din, {m_din[0], m_din[1], m_din[2], m_din[3]});
      check("rand_mode", core_mode, m_mode);
    end
    if (m_busy) pulse_done({$urandom(), $urandom(), $urandom(), $urandom()});
    rd_chk(BASE + 32'h04, "final_status");
    rd_chk(BASE + 32'h30, "final_dout0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_wb_ctrl.md
# aes_wb_ctrl

Wishbone-slave register interface and sequencing FSM between the Caravel management SoC bus and the AES datapath core. It latches a 128-bit key and input block from 32-bit bus writes, launches one encrypt or decrypt operation per software START, and captures the 128-bit result. It also flags completion, errors and watchdog timeouts through status bits and an interrupt line.

## Interface
- BASE_ADDR, 32'h3000_0000: block base address; decoded on wbs_adr_i[31:8].
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before abort; must be >= 2.
- wb_clk_i  in  1  sole clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables for writes.
- wbs_adr_i  in  32  byte address; offset = wbs_adr_i[7:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1, 0 otherwise.
- core_start_o  out  1  one-cycle launch pulse to the AES core.
- core_mode_o  out  1  0 = encrypt, 1 = decrypt; stable from launch to done.
- core_key_o  out  128  key; KEY0 drives [127:96] and KEY3 drives [31:0].
- core_din_o  out  128  input block, same word order as the key.
- core_done_i  in  1  one-cycle completion pulse from the AES core.
- core_dout_i  in  128  result, valid while core_done_i=1.
- irq_o  out  1  interrupt: IRQ_EN & (DONE | ERR).

## Operation
- Register map (offsets):
  - 0x00 CTRL (RW): bit0 START reads 0; bit1 MODE; bit2 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); bit3 TIMEOUT (W1C).
  - 0x10–0x1C KEY0–3: write-only, read 0.
  - 0x20–0x2C DIN0–3: RW.
  - 0x30–0x3C DOUT0–3: RO.
- Bus accesses to unmapped offsets or a non-matching BASE_ADDR page are acked, read 0 and leave state unchanged.
- Writes honour wbs_sel_i per byte. Reads ignore wbs_sel_i.
- FSM has three states: IDLE, LAUNCH and WAIT.
  - IDLE -> LAUNCH: a CTRL write with START=1 while IDLE. MODE is latched from the same write.
  - LAUNCH -> WAIT: unconditional after one cycle. core_start_o=1 only in LAUNCH.
  - WAIT -> IDLE on core_done_i: DOUT <= core_dout_i and DONE set.
  - WAIT -> IDLE on timeout: watchdog reaches TIMEOUT_CYCLES; TIMEOUT and ERR set, DOUT unchanged.
- BUSY = (state != IDLE).
- Writes while BUSY are ignored and set ERR: START=1, any KEY/DIN write, or a MODE change. CTRL writes of IRQ_EN and STATUS W1C writes are always accepted.
- core_done_i is ignored in IDLE and LAUNCH.
- Watchdog: clears on entry to WAIT and increments every WAIT cycle; its width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_start_o=0, core_mode_o=0, core_key_o=0, core_din_o=0, irq_o=0. All registers are 0 and the FSM is in IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. A core_done_i arriving after reset release while IDLE is ignored.
- Ack protocol:
  - wbs_ack_o rises the cycle after cyc&stb is sampled high with ack low. It stays high for exactly one cycle.
  - A held strobe gets one ack per two cycles; this forbids double-acks.
  - Writes commit on the same edge that sets ack.
- Launch timing: a START write committing at edge E puts core_start_o high in cycle E+1. BUSY reads 1 from E+1.
- Completion timing: core_done_i sampled at edge D makes DONE=1, BUSY=0 and the new DOUT visible from D+1. irq_o rises in D+1 if IRQ_EN=1.
- Minimum latency from START commit to DONE is 2 cycles: a core_done_i in the first WAIT cycle.
- Set wins over clear: a DONE/ERR/TIMEOUT set and a W1C of the same bit on the same edge leaves the bit 1.
- A START write on the same edge as done or timeout sees BUSY=1. It is ignored and sets ERR.

## Test plan
- Reset, then read STATUS, DOUT0 and KEY0 -> all read 0x0; irq_o=0; wbs_ack_o exactly 1 cycle per access.
- Encrypt flow:
  - Stimulus: write KEY0–3=0x2b7e1516,0x28aed2a6,0xabf71588,0x09cf4f3c; write DIN0–3=0x3243f6a8,0x885a308d,0x313198a2,0xe0370734; write CTRL=0x5. Core model returns done 10 cycles later with 0x3925841d,0x02dc09fb,0xdc118597,0x196a0b32.
  - Required response: core_start_o is a single pulse with core_key_o = 128'h2b7e...4f3c. STATUS then reads 0x2, DOUT matches and irq_o=1. Writing STATUS=0x2 drops irq_o.
- Busy protection: START, then write DIN0=0xFFFFFFFF while BUSY -> DIN0 is unchanged and STATUS reads 0x5; after done STATUS=0x6.
- Timeout: TIMEOUT_CYCLES=16, core never signals done -> BUSY drops 16 cycles after entering WAIT, STATUS=0xC and DOUT is unchanged; a core_done_i 3 cycles later is ignored.
- Byte lanes: write DIN1=0xAABBCCDD with sel=4'b0101 over DIN1=0 -> DIN1 reads 0x00BB00DD.
- Corner cases:
  - Assert reset during WAIT: all outputs go to reset values.
  - W1C DONE on the same edge as core_done_i: DONE stays 1.
  - Access at BASE_ADDR+0x100: acked, reads 0.
